// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared encodings and defaults for the data memory arbiter
package dmem_arbiter_pkg;

    typedef enum logic {
        ARB_PRIO  = 1'b0,
        ARB_FORCE = 1'b1
    } arb_state_t;

    localparam logic ARB_P0 = 1'b0;
    localparam logic ARB_P1 = 1'b1;

    localparam int DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/dmem_arb_rsp_pipe.sv
// rtl/dmem_arb_rsp_pipe.sv - one-cycle read response owner register and rdata demux
module dmem_arb_rsp_pipe
    import dmem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        rd_fire,
    input  logic        rd_owner,
    input  logic [31:0] mem_q,
    output logic        p0_rsp_valid,
    output logic [31:0] p0_rdata,
    output logic        p1_rsp_valid,
    output logic [31:0] p1_rdata
);

    logic rsp_pending;
    logic rsp_owner;
    logic rsp_live;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rsp_pending <= 1'b0;
            rsp_owner   <= ARB_P0;
        end else begin
            rsp_pending <= rd_fire;
            if (rd_fire) begin
                rsp_owner <= rd_owner;
            end
        end
    end

    // Holding reset kills a response already in flight instead of letting it leak out.
    assign rsp_live     = rsp_pending & resetn;
    assign p0_rsp_valid = rsp_live & (rsp_owner == ARB_P0);
    assign p1_rsp_valid = rsp_live & (rsp_owner == ARB_P1);
    assign p0_rdata     = p0_rsp_valid ? mem_q : 32'h0;
    assign p1_rdata     = p1_rsp_valid ? mem_q : 32'h0;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port dmemory arbiter, fixed priority + starvation guard (DMEM_ARB_RR_EN: round robin)
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [3:0]        p0_mask,
    input  logic [31:0]       p0_wdata,
    output logic              p0_rsp_valid,
    output logic [31:0]       p0_rdata,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [3:0]        p1_mask,
    input  logic [31:0]       p1_wdata,
    output logic              p1_rsp_valid,
    output logic [31:0]       p1_rdata,
    output logic              mem_ceb,
    output logic              mem_web,
    output logic [ADDR_W-1:0] mem_a,
    output logic [3:0]        mem_mask,
    output logic [31:0]       mem_d,
    input  logic [31:0]       mem_q
);

    logic gnt_p0;
    logic gnt_p1;
    logic rd_fire;
    logic rd_owner;

`ifdef DMEM_ARB_RR_EN
    logic last_grant;

    always_comb begin
        gnt_p0 = 1'b0;
        gnt_p1 = 1'b0;
        if (resetn) begin
            if (p0_valid && p1_valid) begin
                gnt_p0 = (last_grant == ARB_P1);
                gnt_p1 = (last_grant == ARB_P0);
            end else begin
                gnt_p0 = p0_valid;
                gnt_p1 = p1_valid;
            end
        end
    end

    // Reset to p1 so that p0 wins the very first contention.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_grant <= ARB_P1;
        end else if (gnt_p0 || gnt_p1) begin
            last_grant <= gnt_p1 ? ARB_P1 : ARB_P0;
        end
    end
`else
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t       state;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        gnt_p0 = 1'b0;
        gnt_p1 = 1'b0;
        if (resetn) begin
            if (state == ARB_FORCE) begin
                gnt_p1 = p1_valid;
                gnt_p0 = p0_valid & ~p1_valid;
            end else begin
                gnt_p0 = p0_valid;
                gnt_p1 = p1_valid & ~p0_valid;
            end
        end
    end

    always_comb begin
        cnt_next = starve_cnt;
        if (!p1_valid || gnt_p1) begin
            cnt_next = '0;
        end else if (starve_cnt != LIMIT) begin
            cnt_next = starve_cnt + 1'b1;
        end
    end

    // Switching on the incoming count lets p1 win on the cycle right after its LIMIT-th refusal.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ARB_PRIO;
            starve_cnt <= '0;
        end else begin
            starve_cnt <= cnt_next;
            case (state)
                ARB_PRIO: begin
                    if (cnt_next == LIMIT) begin
                        state <= ARB_FORCE;
                    end
                end
                ARB_FORCE: begin
                    if (gnt_p1 || !p1_valid) begin
                        state <= ARB_PRIO;
                    end
                end
            endcase
        end
    end
`endif

    assign p0_ready = gnt_p0;
    assign p1_ready = gnt_p1;

    always_comb begin
        mem_ceb  = 1'b1;
        mem_web  = 1'b1;
        mem_a    = '0;
        mem_mask = 4'b0000;
        mem_d    = 32'h0;
        if (gnt_p0) begin
            mem_ceb  = 1'b0;
            mem_web  = ~p0_we;
            mem_a    = p0_addr;
            mem_mask = p0_we ? p0_mask : 4'b0000;
            mem_d    = p0_wdata;
        end else if (gnt_p1) begin
            mem_ceb  = 1'b0;
            mem_web  = ~p1_we;
            mem_a    = p1_addr;
            mem_mask = p1_we ? p1_mask : 4'b0000;
            mem_d    = p1_wdata;
        end
    end

    assign rd_fire  = (gnt_p0 & ~p0_we) | (gnt_p1 & ~p1_we);
    assign rd_owner = gnt_p1 ? ARB_P1 : ARB_P0;

    dmem_arb_rsp_pipe u_rsp_pipe (
        .clk          (clk),
        .resetn       (resetn),
        .rd_fire      (rd_fire),
        .rd_owner     (rd_owner),
        .mem_q        (mem_q),
        .p0_rsp_valid (p0_rsp_valid),
        .p0_rdata     (p0_rdata),
        .p1_rsp_valid (p1_rsp_valid),
        .p1_rdata     (p1_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with memory emulator and behavioural model
module tb_dmem_arbiter;

    localparam int ADDR_W = 10;
    localparam int LIMIT  = 4;

    logic              clk;
    logic              resetn;
    logic              p0_valid, p0_ready, p0_we, p0_rsp_valid;
    logic [ADDR_W-1:0] p0_addr;
    logic [3:0]        p0_mask;
    logic [31:0]       p0_wdata, p0_rdata;
    logic              p1_valid, p1_ready, p1_we, p1_rsp_valid;
    logic [ADDR_W-1:0] p1_addr;
    logic [3:0]        p1_mask;
    logic [31:0]       p1_wdata, p1_rdata;
    logic              mem_ceb, mem_web;
    logic [ADDR_W-1:0] mem_a;
    logic [3:0]        mem_mask;
    logic [31:0]       mem_d, mem_q;

    int n_cmp  = 0;
    int n_fail = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .clk(clk), .resetn(resetn),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_mask(p0_mask), .p0_wdata(p0_wdata), .p0_rsp_valid(p0_rsp_valid), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_mask(p1_mask), .p1_wdata(p1_wdata), .p1_rsp_valid(p1_rsp_valid), .p1_rdata(p1_rdata),
        .mem_ceb(mem_ceb), .mem_web(mem_web), .mem_a(mem_a), .mem_mask(mem_mask),
        .mem_d(mem_d), .mem_q(mem_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory emulator driving mem_q, and an independent reference image for the model.
    logic [31:0] emu_mem [0:1023];
    logic [31:0] ref_mem [0:1023];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            emu_mem[i] = 32'hC0DE_0000 | i;
            ref_mem[i] = 32'hC0DE_0000 | i;
        end
        mem_q = 32'h0;
    end

    always @(posedge clk) begin
        if (!mem_ceb) begin
            if (!mem_web) begin
                for (int b = 0; b < 4; b++)
                    if (mem_mask[b]) emu_mem[mem_a][8*b +: 8] <= mem_d[8*b +: 8];
            end else begin
                mem_q <= emu_mem[mem_a];
            end
        end
    end

    // Behavioural model: p1 may be turned away at most LIMIT cycles in a row.
    int          refused   = 0;
    logic        rr_last1  = 1'b1;
    logic        pend_v    = 1'b0;
    logic        pend_port = 1'b0;
    logic [31:0] pend_data = 32'h0;

    always @(negedge clk) begin
        logic        g0, g1, we;
        logic [9:0]  a;
        logic [3:0]  m;
        logic [31:0] d;
        if (!resetn) begin
            chk("rst_p0_ready", {31'b0, p0_ready}, 32'd0);
            chk("rst_p1_ready", {31'b0, p1_ready}, 32'd0);
            chk("rst_mem_ceb", {31'b0, mem_ceb}, 32'd1);
            chk("rst_mem_web", {31'b0, mem_web}, 32'd1);
            chk("rst_p0_rsp", {31'b0, p0_rsp_valid}, 32'd0);
            chk("rst_p1_rsp", {31'b0, p1_rsp_valid}, 32'd0);
            refused  = 0;
            rr_last1 = 1'b1;
            pend_v   = 1'b0;
        end else begin
`ifdef DMEM_ARB_RR_EN
            g1 = p1_valid && (!p0_valid || !rr_last1);
`else
            g1 = p1_valid && (!p0_valid || refused >= LIMIT);
`endif
            g0 = p0_valid && !g1;
            we = g1 ? p1_we : p0_we;
            a  = g1 ? p1_addr : (g0 ? p0_addr : 10'h0);
            m  = (g0 || g1) && we ? (g1 ? p1_mask : p0_mask) : 4'h0;
            d  = g1 ? p1_wdata : (g0 ? p0_wdata : 32'h0);
            chk("p0_ready", {31'b0, p0_ready}, {31'b0, g0});
            chk("p1_ready", {31'b0, p1_ready}, {31'b0, g1});
            chk("mem_ceb", {31'b0, mem_ceb}, {31'b0, !(g0 || g1)});
            chk("mem_web", {31'b0, mem_web}, {31'b0, !((g0 || g1) && we)});
            chk("mem_a", {22'b0, mem_a}, {22'b0, a});
            chk("mem_mask", {28'b0, mem_mask}, {28'b0, m});
            chk("mem_d", mem_d, d);
            chk("p0_rsp_valid", {31'b0, p0_rsp_valid}, {31'b0, pend_v && !pend_port});
            chk("p1_rsp_valid", {31'b0, p1_rsp_valid}, {31'b0, pend_v && pend_port});
            if (pend_v) begin
                chk("p0_rdata", p0_rdata, pend_port ? 32'h0 : pend_data);
                chk("p1_rdata", p1_rdata, pend_port ? pend_data : 32'h0);
            end
            pend_v = (g0 || g1) && !we;
            if (pend_v) begin
                pend_port = g1;
                pend_data = ref_mem[a];
            end
            if ((g0 || g1) && we)
                for (int b = 0; b < 4; b++)
                    if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
            if (g0 || g1) rr_last1 = g1;
            if (p1_valid && !g1) refused = refused + 1;
            else refused = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        p0_valid = 0; p0_we = 0; p0_addr = '0; p0_mask = 0; p0_wdata = 0;
        p1_valid = 0; p1_we = 0; p1_addr = '0; p1_mask = 0; p1_wdata = 0;
    endtask

    task automatic drv0(input logic v, input logic w, input logic [9:0] a, input logic [3:0] m, input logic [31:0] d);
        p0_valid = v; p0_we = w; p0_addr = a; p0_mask = m; p0_wdata = d;
    endtask

    task automatic drv1(input logic v, input logic w, input logic [9:0] a, input logic [3:0] m, input logic [31:0] d);
        p1_valid = v; p1_we = w; p1_addr = a; p1_mask = m; p1_wdata = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] p1_pat;
        resetn = 1'b0;
        idle();
        step();
        settle();
        chk("lit_reset_ceb", {31'b0, mem_ceb}, 32'd1);
        step();
        resetn = 1'b1;

        // Lone p0 read
        drv0(1, 0, 10'h004, 4'hF, 32'h0);
        settle();
        chk("lit_t1_ready", {31'b0, p0_ready}, 32'd1);
        chk("lit_t1_addr", {22'b0, mem_a}, 32'h004);
        step();
        idle();
        settle();
        chk("lit_t1_rsp", {31'b0, p0_rsp_valid}, 32'd1);
        chk("lit_t1_rdata", p0_rdata, 32'hC0DE_0004);
        step();

        // p0 write collides with p1 read of the same word
        drv0(1, 1, 10'h010, 4'b0011, 32'hA5A5_1234);
        drv1(1, 0, 10'h010, 4'h0, 32'h0);
        settle();
`ifndef DMEM_ARB_RR_EN
        chk("lit_t2_mask", {28'b0, mem_mask}, 32'h3);
`endif
        step();
        drv0(0, 0, 10'h0, 4'h0, 32'h0);
        settle();
        chk("lit_t2_p1_ready", {31'b0, p1_ready}, 32'd1);
        step();
        idle();
        settle();
        chk("lit_t2_p1_rsp", {31'b0, p1_rsp_valid}, 32'd1);
`ifndef DMEM_ARB_RR_EN
        chk("lit_t2_p1_rdata", p1_rdata, 32'hC0DE_1234);
`endif
        step();

        // Continuous contention
        drv0(1, 0, 10'h020, 4'h0, 32'h0);
        drv1(1, 0, 10'h030, 4'h0, 32'h0);
        for (int i = 0; i < 12; i++) begin
            settle();
            p1_pat[i] = p1_ready;
            step();
        end
`ifdef DMEM_ARB_RR_EN
        chk("lit_t3_pattern", {20'b0, p1_pat}, 32'h0000_0AAA);
`else
        chk("lit_t3_pattern", {20'b0, p1_pat}, 32'h0000_0210);
`endif
        idle();
        step();
        step();

        // Back-to-back reads alternating ports
        drv0(1, 0, 10'h001, 4'h0, 32'h0);
        step();
        drv0(0, 0, 10'h0, 4'h0, 32'h0);
        drv1(1, 0, 10'h002, 4'h0, 32'h0);
        settle();
        chk("lit_t4_rd1", p0_rdata, 32'hC0DE_0001);
        step();
        drv1(0, 0, 10'h0, 4'h0, 32'h0);
        drv0(1, 0, 10'h003, 4'h0, 32'h0);
        settle();
        chk("lit_t4_rd2", p1_rdata, 32'hC0DE_0002);
        step();
        idle();
        settle();
        chk("lit_t4_rd3", p0_rdata, 32'hC0DE_0003);
        step();

        // Write directly behind a read of the same word, then read back
        drv0(1, 0, 10'h040, 4'h0, 32'h0);
        step();
        drv0(1, 1, 10'h040, 4'hF, 32'h1234_5678);
        settle();
        chk("lit_t5_old", p0_rdata, 32'hC0DE_0040);
        step();
        drv0(1, 0, 10'h040, 4'h0, 32'h0);
        step();
        idle();
        settle();
        chk("lit_t5_new", p0_rdata, 32'h1234_5678);
        step();

        // p1 partial write and read-back
        drv1(1, 1, 10'h050, 4'b1100, 32'hFFFF_0000);
        step();
        drv1(1, 0, 10'h050, 4'h0, 32'h0);
        step();
        idle();
        settle();
        chk("lit_t6_p1_merge", p1_rdata, 32'hFFFF_0050);
        step();

        // Reset right behind a granted read
        drv0(1, 0, 10'h005, 4'h0, 32'h0);
        step();
        idle();
        resetn = 1'b0;
        settle();
        chk("lit_t7_rsp", {31'b0, p0_rsp_valid}, 32'd0);
        chk("lit_t7_ceb", {31'b0, mem_ceb}, 32'd1);
        step();
        resetn = 1'b1;
        settle();
        chk("lit_t7_after", {31'b0, p0_rsp_valid}, 32'd0);
        step();

        // Contention again after reset: starvation count must restart from zero
        drv0(1, 0, 10'h060, 4'h0, 32'h0);
        drv1(1, 0, 10'h070, 4'h0, 32'h0);
        for (int i = 0; i < 6; i++) step();
        idle();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
